// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the streaming Sobel filter: image RAM read-out, filter reset control and
// gradient write-back to the edge RAM. Define SOBEL_THRESH_EN for a binary edge map output.
module sobel_frame_ctrl #(
  parameter int IMG_W     = 4,
  parameter int IMG_H     = 4,
  parameter int PIX_W     = 8,
  parameter int ADDR_W    = 6,
  parameter int FLUSH_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [10:0]       thresh,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              sobel_rst,
  output logic [PIX_W-1:0]  sobel_pixel,
  input  logic [10:0]       grad_in,
  input  logic              grad_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int N     = IMG_W * IMG_H;
  localparam int E     = (IMG_W - 2) * (IMG_H - 2);
  localparam int CNT_W = ADDR_W + 1;
  localparam int FL_W  = $clog2(FLUSH_MAX + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N - 1);
  localparam logic [CNT_W-1:0]  E_CNT      = CNT_W'(E);
  localparam logic [FL_W-1:0]   FLUSH_LAST = FL_W'(FLUSH_MAX - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]        state_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic              rd_en_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              sobel_rst_r;
  logic [FL_W-1:0]   flush_cnt_r;
  logic [CNT_W-1:0]  wr_cnt_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [7:0]        wr_data_r;

  logic              start_acc_s;
  logic              accept_s;
  logic              flush_exit_s;
  logic [7:0]        wr_data_s;

  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
  assign rd_en       = rd_en_r;
  assign rd_addr     = rd_addr_r;
  assign sobel_rst   = sobel_rst_r;
  assign sobel_pixel = rd_data;
  assign wr_en       = wr_en_r;
  assign wr_addr     = wr_addr_r;
  assign wr_data     = wr_data_r;

  assign start_acc_s = (state_r == ST_IDLE) && start;

  // Gradients only count while a frame is in flight and the edge map is not yet full.
  always_comb begin
    accept_s = 1'b0;
    if ((state_r == ST_STREAM || state_r == ST_FLUSH) && grad_valid && (wr_cnt_r < E_CNT)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Never leave FLUSH on a cycle that accepts a gradient, so done always trails the last write.
  assign flush_exit_s = !accept_s && ((wr_cnt_r == E_CNT) || (flush_cnt_r >= FLUSH_LAST));

`ifdef SOBEL_THRESH_EN
  logic [10:0] thresh_r;

  assign wr_data_s = (grad_in >= thresh_r) ? 8'hFF : 8'h00;

  // Threshold is frozen at start acceptance for the whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      thresh_r <= 11'd0;
    end else if (start_acc_s) begin
      thresh_r <= thresh;
    end
  end
`else
  logic unused_thresh_s;

  assign unused_thresh_s = ^thresh;
  assign wr_data_s       = (grad_in > 11'd255) ? 8'hFF : grad_in[7:0];
`endif

  // Frame sequencing: read-out, flush wait and completion status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= '0;
      sobel_rst_r <= 1'b1;
      flush_cnt_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          sobel_rst_r <= 1'b1;
          if (start) begin
            state_r     <= ST_STREAM;
            busy_r      <= 1'b1;
            err_r       <= 1'b0;
            rd_en_r     <= 1'b1;
            rd_addr_r   <= '0;
            flush_cnt_r <= '0;
          end
        end
        ST_STREAM: begin
          sobel_rst_r <= 1'b0;
          if (rd_addr_r == LAST_ADDR) begin
            rd_en_r     <= 1'b0;
            flush_cnt_r <= '0;
            state_r     <= ST_FLUSH;
          end else begin
            rd_addr_r <= rd_addr_r + ADDR_W'(1);
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_r < FLUSH_LAST) begin
            flush_cnt_r <= flush_cnt_r + FL_W'(1);
          end
          if (flush_exit_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            err_r   <= (wr_cnt_r < E_CNT);
          end
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          sobel_rst_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          rd_en_r     <= 1'b0;
          sobel_rst_r <= 1'b1;
        end
      endcase
    end
  end

  // Edge RAM write port and result counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= 8'h00;
      wr_cnt_r  <= '0;
    end else begin
      wr_en_r <= accept_s;
      if (accept_s) begin
        wr_addr_r <= wr_cnt_r[ADDR_W-1:0];
        wr_data_r <= wr_data_s;
      end
      if (start_acc_s) begin
        wr_cnt_r <= '0;
      end else if (accept_s) begin
        wr_cnt_r <= wr_cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl with image RAM, edge RAM monitor and a behavioural filter
// that emits a fixed gradient for every full 3x3 window.
module tb_sobel_frame_ctrl;

  localparam int IMG_W     = 4;
  localparam int IMG_H     = 4;
  localparam int PIX_W     = 8;
  localparam int ADDR_W    = 6;
  localparam int FLUSH_MAX = 16;
  localparam int N         = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [10:0]       thresh;
  logic              busy, done, err, rd_en, sobel_rst, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [PIX_W-1:0]  rd_data, sobel_pixel;
  logic [7:0]        wr_data;
  logic [10:0]       grad_in;
  logic              grad_valid;

  logic              gv_model = 1'b0;
  logic [10:0]       gi_model = 11'd0;
  logic              gv_force = 1'b0;
  logic              gen_en   = 1'b1;
  logic [10:0]       grad_val = 11'd0;
  logic [7:0]        img [0:N-1];

  int tests = 0;
  int fails = 0;

  assign grad_valid = gv_model | gv_force;
  assign grad_in    = gv_force ? 11'd500 : gi_model;

  always #5 clk = ~clk;

  sobel_frame_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .FLUSH_MAX(FLUSH_MAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .thresh(thresh),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .sobel_rst(sobel_rst), .sobel_pixel(sobel_pixel),
    .grad_in(grad_in), .grad_valid(grad_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Image RAM with one cycle read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= img[rd_addr[3:0]];
  end

  // Filter model: checks each sampled pixel and emits grad_val one cycle after a full window.
  int fp = 0;
  int pix_bad = 0;
  always @(posedge clk) begin
    if (sobel_rst) begin
      fp       <= 0;
      gv_model <= 1'b0;
      gi_model <= 11'd0;
    end else begin
      gv_model <= 1'b0;
      if (fp < N) begin
        fp <= fp + 1;
        if (sobel_pixel !== img[fp]) pix_bad <= pix_bad + 1;
        if (gen_en && (fp / IMG_W) >= 2 && (fp % IMG_W) >= 2) begin
          gv_model <= 1'b1;
          gi_model <= grad_val;
        end
      end
    end
  end

  // Output monitor: edge RAM writes, done pulses and read address continuity.
  int cyc = 0, wr_total = 0, done_total = 0, rd_total = 0, rd_bad = 0;
  int last_wr_cyc = 0, done_cyc = 0;
  logic              rd_en_q = 1'b0;
  logic [ADDR_W-1:0] rd_addr_q = '0;
  logic [ADDR_W-1:0] wa [0:255];
  logic [7:0]        wd [0:255];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wr_en === 1'b1) begin
      wa[wr_total[7:0]] <= wr_addr;
      wd[wr_total[7:0]] <= wr_data;
      wr_total    <= wr_total + 1;
      last_wr_cyc <= cyc;
    end
    if (done === 1'b1) begin
      done_total <= done_total + 1;
      done_cyc   <= cyc;
    end
    if (rd_en === 1'b1) begin
      rd_total <= rd_total + 1;
      if (rd_addr !== (rd_en_q ? rd_addr_q + 6'd1 : 6'd0)) rd_bad <= rd_bad + 1;
    end
    rd_en_q   <= rd_en;
    rd_addr_q <= rd_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one frame from a start pulse; optionally re-pulses start at loop step restart_at.
  task automatic run_frame(input string tag, input int restart_at, input logic exp_err,
                           input int exp_flush);
    int   flush_cyc = 0;
    bit   seen_rd = 1'b0, got_done = 1'b0;
    logic err_at_done = 1'b0, busy_at_done = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    thresh = 11'd2000;
    for (int i = 0; i < 200 && !got_done; i++) begin
      if (rd_en === 1'b1) seen_rd = 1'b1;
      if (done === 1'b1) begin
        got_done     = 1'b1;
        err_at_done  = err;
        busy_at_done = busy;
      end else if (seen_rd && busy === 1'b1 && rd_en === 1'b0) begin
        flush_cyc++;
      end
      start = (i == restart_at);
      if (!got_done) @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(got_done), 32'd1);
    check({tag, "_err"}, 32'(err_at_done), 32'(exp_err));
    check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd1);
    check({tag, "_flush_cycles"}, flush_cyc, exp_flush);
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_sobel_rst_after"}, 32'(sobel_rst), 32'd1);
  endtask

  task automatic check_writes(input string tag, input int base, input int dbase, input int nexp,
                              input logic [7:0] exp_data);
    check({tag, "_nwr"}, wr_total - base, nexp);
    check({tag, "_ndone"}, done_total - dbase, 32'd1);
    for (int i = 0; i < nexp; i++) begin
      check({tag, "_wr_addr"}, 32'(wa[(base + i) % 256]), i);
      check({tag, "_wr_data"}, 32'(wd[(base + i) % 256]), 32'(exp_data));
    end
    if (nexp > 0) check({tag, "_done_after_wr"}, 32'(done_cyc > last_wr_cyc), 32'd1);
  endtask

  initial begin
    int base, dbase, rbase;
    logic [7:0] exp7;
    rst = 1'b1; start = 1'b0; thresh = 11'd0;
    for (int i = 0; i < N; i++) img[i] = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_rd", 32'({rd_en, rd_addr}), 32'd0);
    check("rst_wr", 32'({wr_en, wr_addr, wr_data}), 32'd0);
    check("rst_sobel_rst", 32'(sobel_rst), 32'd1);
    rst = 1'b0;

    // Gradient strobes while idle must be dropped.
    gv_force = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_wr_en", 32'(wr_en), 32'd0);
    gv_force = 1'b0;
    @(negedge clk);
    check("t6_nwr", wr_total, 32'd0);
    check("t6_wr_addr", 32'(wr_addr), 32'd0);

    // Flat frame: zero gradient, binary or saturated output both 0.
    for (int i = 0; i < N; i++) img[i] = 8'd10;
    grad_val = 11'd0; thresh = 11'd50;
    base = wr_total; dbase = done_total;
    run_frame("t1", -1, 1'b0, 3);
    check_writes("t1", base, dbase, 4, 8'h00);

    // Vertical edge: gradient 400 against threshold 200, or saturated.
    for (int i = 0; i < N; i++) img[i] = ((i % IMG_W) >= 2) ? 8'd100 : 8'd0;
    grad_val = 11'd400; thresh = 11'd200;
    base = wr_total; dbase = done_total;
    run_frame("t2", -1, 1'b0, 3);
    check_writes("t2", base, dbase, 4, 8'hFF);

    // start re-pulsed mid-stream must not disturb the frame.
    thresh = 11'd200;
    base = wr_total; dbase = done_total; rbase = rd_total;
    run_frame("t3", 5, 1'b0, 3);
    check_writes("t3", base, dbase, 4, 8'hFF);
    check("t3_rd_count", rd_total - rbase, 32'd16);
    repeat (30) @(negedge clk);
    check("t3_no_restart", 32'({busy, 8'(done_total - dbase)}), 32'd1);

    // Reset in the middle of streaming, then a clean frame.
    thresh = 11'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("t4_rd_addr6", 32'(rd_addr), 32'd6);
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_sobel_rst", 32'(sobel_rst), 32'd1);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_wr_rd", 32'({wr_en, rd_en, rd_addr}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    thresh = 11'd200;
    base = wr_total; dbase = done_total;
    run_frame("t4", -1, 1'b0, 3);
    check_writes("t4", base, dbase, 4, 8'hFF);

    // Silent filter: flush times out after FLUSH_MAX cycles with err.
    gen_en = 1'b0;
    base = wr_total; dbase = done_total;
    run_frame("t5", -1, 1'b1, FLUSH_MAX);
    check_writes("t5", base, dbase, 0, 8'h00);
    gen_en = 1'b1;

    // Mid-range gradient: threshold latched at start (50) versus plain magnitude 100.
    grad_val = 11'd100; thresh = 11'd50;
`ifdef SOBEL_THRESH_EN
    exp7 = 8'hFF;
`else
    exp7 = 8'h64;
`endif
    base = wr_total; dbase = done_total;
    run_frame("t7", -1, 1'b0, 3);
    check_writes("t7", base, dbase, 4, exp7);

    check("pix_stream", pix_bad, 32'd0);
    check("rd_addr_seq", rd_bad, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
